// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch sequencer state encoding, PC step and default reset vector.
package cpu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_I,
    EXEC,
    STALL_D
  } fetch_state_e;

  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Fetch-side bus bundle: instruction cache handshake, data cache busy, branch controls and decode outputs.
interface fetch_sequencer_if #(
  parameter int OFFSET_W = 8
);

  logic [31:0]                PC;
  logic                       IMEM_READ;
  logic [31:0]                IMEM_ADDRESS;
  logic [31:0]                IMEM_READDATA;
  logic                       IMEM_BUSYWAIT;
  logic                       DMEM_BUSYWAIT;
  logic [31:0]                INSTRUCTION;
  logic                       INSTR_VALID;
  logic                       BRANCH;
  logic                       JUMP;
  logic                       ZERO;
  logic signed [OFFSET_W-1:0] RD_OFFSET;
  logic                       FETCH_TIMEOUT;

  // Sequencer side.
  modport master (
    output PC, IMEM_READ, IMEM_ADDRESS, INSTRUCTION, INSTR_VALID, FETCH_TIMEOUT,
    input  IMEM_READDATA, IMEM_BUSYWAIT, DMEM_BUSYWAIT, BRANCH, JUMP, ZERO, RD_OFFSET
  );

  // Caches, control unit and ALU side.
  modport slave (
    input  PC, IMEM_READ, IMEM_ADDRESS, INSTRUCTION, INSTR_VALID, FETCH_TIMEOUT,
    output IMEM_READDATA, IMEM_BUSYWAIT, DMEM_BUSYWAIT, BRANCH, JUMP, ZERO, RD_OFFSET
  );

endinterface

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: PC+4, or PC+4 plus the scaled signed word offset on jump / taken branch.
module next_pc_calc
  import cpu_pkg::*;
#(
  parameter int OFFSET_W = 8
) (
  input  logic [31:0]                PC,
  input  logic signed [OFFSET_W-1:0] RD_OFFSET,
  input  logic                       BRANCH,
  input  logic                       JUMP,
  input  logic                       ZERO,
  output logic [31:0]                NEXTPC
);

  logic [31:0]        pc_plus4;
  logic signed [31:0] offset_ext;
  logic [31:0]        target;

  assign pc_plus4   = PC + PC_STEP;
  assign offset_ext = 32'(RD_OFFSET);
  // Wrap-around is intentional: all arithmetic is modulo 2^32.
  assign target     = pc_plus4 + $unsigned(offset_ext <<< 2);

  always_comb begin
    NEXTPC = pc_plus4;
    if (JUMP || (BRANCH && ZERO)) begin
      NEXTPC = target;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch sequencer owning the PC and instruction-cache handshake.
// Optional performance counters are enabled with the FETCH_PERF_CNT_EN macro.
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          OFFSET_W   = 8,
  parameter int          WAIT_LIMIT = 255
) (
  input  logic               CLK,
  input  logic               RESET,
  fetch_sequencer_if.master  bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        INSTR_COUNT,
  output logic [31:0]        STALL_COUNT
`endif
);

  localparam int             CNT_W    = $clog2(WAIT_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(WAIT_LIMIT);
  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(WAIT_LIMIT - 1);

  fetch_state_e     state_q, state_d;
  logic [31:0]      pc;
  logic [31:0]      next_pc;
  logic [31:0]      instr;
  logic [CNT_W-1:0] wait_cnt;
  logic             timeout;
  logic             pc_upd;
  logic             capture;
  logic             imem_read;
  logic             instr_valid;

  next_pc_calc #(
    .OFFSET_W (OFFSET_W)
  ) u_next_pc (
    .PC        (pc),
    .RD_OFFSET (bus.RD_OFFSET),
    .BRANCH    (bus.BRANCH),
    .JUMP      (bus.JUMP),
    .ZERO      (bus.ZERO),
    .NEXTPC    (next_pc)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Handshake outputs are decoded from state so a reset drops them without a clock.
  always_comb begin
    state_d     = state_q;
    pc_upd      = 1'b0;
    capture     = 1'b0;
    imem_read   = 1'b0;
    instr_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        state_d = FETCH;
      end
      FETCH, WAIT_I: begin
        imem_read = 1'b1;
        if (!bus.IMEM_BUSYWAIT) begin
          capture = 1'b1;
          state_d = EXEC;
        end else begin
          state_d = WAIT_I;
        end
      end
      EXEC, STALL_D: begin
        instr_valid = 1'b1;
        if (bus.DMEM_BUSYWAIT) begin
          state_d = STALL_D;
        end else begin
          pc_upd  = 1'b1;
          state_d = FETCH;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pc       <= RESET_PC;
      instr    <= '0;
      wait_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      if (pc_upd) begin
        pc <= next_pc;
      end
      if (capture) begin
        instr <= bus.IMEM_READDATA;
      end
      // Counter saturates at the limit; the timeout flag is sticky until reset.
      if (state_q == WAIT_I) begin
        if (capture) begin
          wait_cnt <= '0;
        end else begin
          if (wait_cnt != LIMIT) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
          if (wait_cnt == LIMIT_M1) begin
            timeout <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.PC            = pc;
  assign bus.IMEM_ADDRESS  = pc;
  assign bus.IMEM_READ     = imem_read;
  assign bus.INSTRUCTION   = instr;
  assign bus.INSTR_VALID   = instr_valid;
  assign bus.FETCH_TIMEOUT = timeout;

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      INSTR_COUNT <= '0;
      STALL_COUNT <= '0;
    end else begin
      if (pc_upd) begin
        INSTR_COUNT <= INSTR_COUNT + 32'd1;
      end
      if (state_q == WAIT_I || state_q == STALL_D) begin
        STALL_COUNT <= STALL_COUNT + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed vector table, async-reset and timeout sequences,
// and randomized instructions checked against a per-instruction transaction model.
module tb_fetch_sequencer;

  localparam int TB_WAIT_LIMIT = 4;

  logic CLK = 1'b0;
  logic RESET;

  fetch_sequencer_if #(.OFFSET_W(8)) bus ();

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] INSTR_COUNT;
  logic [31:0] STALL_COUNT;
`endif

  fetch_sequencer #(
    .RESET_PC   (32'h0000_0000),
    .OFFSET_W   (8),
    .WAIT_LIMIT (TB_WAIT_LIMIT)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
`ifdef FETCH_PERF_CNT_EN
    ,
    .INSTR_COUNT (INSTR_COUNT),
    .STALL_COUNT (STALL_COUNT)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int                 busy_i;
    int                 busy_d;
    logic               br;
    logic               jp;
    logic               z;
    logic signed [7:0]  off;
    logic [31:0]        data;
    logic [31:0]        exp_pc;
  } vec_t;

  vec_t vecs [12];

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] m_pc;
  logic        m_to;
  logic [31:0] m_instr;
  logic [31:0] m_stall;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_next_pc(input logic [31:0] pc, input logic br,
                                              input logic jp, input logic z,
                                              input logic signed [7:0] off);
    longint t;
    t = longint'(pc) + 64'sd4 + 64'sd4 * longint'(off);
    if (jp || (br && z)) return t[31:0];
    return pc + 32'd4;
  endfunction

  task automatic drive_junk();
    bus.BRANCH    = 1'($urandom);
    bus.JUMP      = 1'($urandom);
    bus.ZERO      = 1'($urandom);
    bus.RD_OFFSET = 8'($urandom);
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    #1;
    check("rst_pc", bus.PC, 32'h0);
    check("rst_imem_read", 32'(bus.IMEM_READ), 32'd0);
    check("rst_instruction", bus.INSTRUCTION, 32'h0);
    check("rst_valid", 32'(bus.INSTR_VALID), 32'd0);
    check("rst_timeout", 32'(bus.FETCH_TIMEOUT), 32'd0);
`ifdef FETCH_PERF_CNT_EN
    check("rst_instr_count", INSTR_COUNT, 32'd0);
    check("rst_stall_count", STALL_COUNT, 32'd0);
`endif
    m_pc    = 32'h0;
    m_to    = 1'b0;
    m_instr = 32'd0;
    m_stall = 32'd0;
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    @(negedge CLK);
    check("idle_imem_read", 32'(bus.IMEM_READ), 32'd0);
    check("idle_valid", 32'(bus.INSTR_VALID), 32'd0);
    @(posedge CLK);
    #1;
  endtask

  // Entered just after the edge that puts the sequencer into FETCH.
  task automatic run_instr(input int bi, input int bd, input logic br, input logic jp,
                           input logic z, input logic signed [7:0] off,
                           input logic [31:0] data, input logic [31:0] exp_next);
    for (int k = 0; k <= bi; k++) begin
      bus.IMEM_BUSYWAIT = (k < bi);
      bus.IMEM_READDATA = (k < bi) ? $urandom : data;
      bus.DMEM_BUSYWAIT = 1'($urandom);
      drive_junk();
      @(negedge CLK);
      check("fetch_imem_read", 32'(bus.IMEM_READ), 32'd1);
      check("fetch_imem_addr", bus.IMEM_ADDRESS, m_pc);
      check("fetch_pc", bus.PC, m_pc);
      check("fetch_valid", 32'(bus.INSTR_VALID), 32'd0);
      check("fetch_timeout", 32'(bus.FETCH_TIMEOUT), 32'(m_to || (k > TB_WAIT_LIMIT)));
      @(posedge CLK);
      #1;
    end
    if (bi > TB_WAIT_LIMIT) m_to = 1'b1;
    m_stall = m_stall + 32'(bi);
    for (int k = 0; k <= bd; k++) begin
      bus.IMEM_BUSYWAIT = 1'($urandom);
      bus.IMEM_READDATA = $urandom;
      bus.DMEM_BUSYWAIT = (k < bd);
      if (k == bd) begin
        bus.BRANCH    = br;
        bus.JUMP      = jp;
        bus.ZERO      = z;
        bus.RD_OFFSET = off;
      end else begin
        drive_junk();
      end
      @(negedge CLK);
      check("exec_imem_read", 32'(bus.IMEM_READ), 32'd0);
      check("exec_valid", 32'(bus.INSTR_VALID), 32'd1);
      check("exec_instruction", bus.INSTRUCTION, data);
      check("exec_pc_held", bus.PC, m_pc);
      check("exec_timeout", 32'(bus.FETCH_TIMEOUT), 32'(m_to));
`ifdef FETCH_PERF_CNT_EN
      if (k == 0) begin
        check("instr_count", INSTR_COUNT, m_instr);
        check("stall_count", STALL_COUNT, m_stall);
      end
`endif
      @(posedge CLK);
      #1;
    end
    m_stall = m_stall + 32'(bd);
    m_instr = m_instr + 32'd1;
    m_pc    = exp_next;
  endtask

  initial begin
    RESET             = 1'b0;
    bus.IMEM_READDATA = '0;
    bus.IMEM_BUSYWAIT = 1'b0;
    bus.DMEM_BUSYWAIT = 1'b0;
    bus.BRANCH        = 1'b0;
    bus.JUMP          = 1'b0;
    bus.ZERO          = 1'b0;
    bus.RD_OFFSET     = '0;

    vecs[0]  = '{0, 0, 1'b0, 1'b0, 1'b0,  8'sd0, 32'h1111_0000, 32'd4};
    vecs[1]  = '{0, 5, 1'b0, 1'b0, 1'b0,  8'sd0, 32'h2222_0004, 32'd8};
    vecs[2]  = '{3, 0, 1'b0, 1'b0, 1'b0,  8'sd0, 32'h3333_0008, 32'd12};
    vecs[3]  = '{0, 0, 1'b0, 1'b0, 1'b0,  8'sd0, 32'h4444_000C, 32'd16};
    vecs[4]  = '{0, 0, 1'b1, 1'b0, 1'b1, -8'sd2, 32'h5555_0010, 32'd12};
    vecs[5]  = '{0, 0, 1'b0, 1'b0, 1'b0,  8'sd0, 32'h6666_000C, 32'd16};
    vecs[6]  = '{0, 0, 1'b1, 1'b0, 1'b0, -8'sd2, 32'h7777_0010, 32'd20};
    vecs[7]  = '{0, 0, 1'b0, 1'b1, 1'b0, -8'sd2, 32'h8888_0014, 32'd16};
    vecs[8]  = '{0, 0, 1'b1, 1'b1, 1'b0,  8'sd3, 32'h9999_0010, 32'd32};
    vecs[9]  = '{0, 0, 1'b0, 1'b1, 1'b0, -8'sd9, 32'hAAAA_0020, 32'd0};
    vecs[10] = '{0, 0, 1'b0, 1'b1, 1'b1, -8'sd2, 32'hBBBB_0000, 32'hFFFF_FFFC};
    vecs[11] = '{1, 1, 1'b0, 1'b0, 1'b0,  8'sd0, 32'hCCCC_FFFC, 32'd0};

    #3;
    do_reset();

    for (int i = 0; i < 12; i++) begin
      run_instr(vecs[i].busy_i, vecs[i].busy_d, vecs[i].br, vecs[i].jp, vecs[i].z,
                vecs[i].off, vecs[i].data, vecs[i].exp_pc);
    end

    for (int i = 0; i < 40; i++) begin
      int                bi, bd;
      logic              br, jp, z;
      logic signed [7:0] off;
      bi  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 7)) : 0;
      bd  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 6)) : 0;
      br  = 1'($urandom);
      jp  = ($urandom_range(0, 3) == 0);
      z   = 1'($urandom);
      off = 8'($urandom);
      run_instr(bi, bd, br, jp, z, off, $urandom, ref_next_pc(m_pc, br, jp, z, off));
    end

    // Asynchronous reset in the middle of an instruction wait at PC=40.
    do_reset();
    run_instr(0, 0, 1'b0, 1'b1, 1'b0, 8'sd9, 32'hDEAD_0000, 32'd40);
    bus.IMEM_BUSYWAIT = 1'b1;
    drive_junk();
    @(posedge CLK);
    #1;
    @(negedge CLK);
    check("wait_imem_read", 32'(bus.IMEM_READ), 32'd1);
    check("wait_imem_addr", bus.IMEM_ADDRESS, 32'd40);
    #2;
    do_reset();

    // Timeout boundary: four busy cycles stay below the limit, ten cross it.
    run_instr(4, 0, 1'b0, 1'b0, 1'b0, 8'sd0, 32'h0BAD_0000, 32'd4);
    run_instr(10, 1, 1'b0, 1'b0, 1'b0, 8'sd0, 32'h0BAD_0004, 32'd8);
    run_instr(0, 0, 1'b0, 1'b0, 1'b0, 8'sd0, 32'h0BAD_0008, 32'd12);

    @(negedge CLK);
    check("final_pc", bus.PC, m_pc);
    check("final_timeout", 32'(bus.FETCH_TIMEOUT), 32'(m_to));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
